dro_pulse_scheduler: RTL

Synchronous controller that shares one DRO (destructive-readout) cell between NREQ requesters. Requests are write (pulse `set`) or read (pulse `reset`, then capture `out`). The block serialises requests round-robin and enforces the minimum set-to-reset and reset-to-set spacing the DRO timing checks require, so no caller can cause a timing violation. It sits between the requester fabric and the `set`/`reset`/`out` pins of the DRO instance.

---
 rtl/dro_pulse_scheduler.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dro_pulse_scheduler.sv
// Round-robin scheduler sharing one DRO cell between NREQ requesters,
// enforcing set/reset pulse spacing and sampling dro_out after readout.
module dro_pulse_scheduler #(
  parameter int NREQ    = 2,
  parameter int SET_GAP = 3,
  parameter int RST_GAP = 2,
  parameter int RD_WIN  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] op,
  output logic [NREQ-1:0] gnt,
  output logic            done,
  output logic [2:0]      done_id,
  output logic            rd_data,
  output logic            busy,
  output logic            stored,
  output logic            spur,
  output logic            dro_set,
  output logic            dro_reset,
  input  logic            dro_out
);

  typedef enum logic [2:0] {IDLE, GNT, WAIT, PULSE, RDWIN} state_t;

  localparam logic [2:0] LAST = 3'(NREQ - 1);
  localparam logic [3:0] NR4  = 4'(NREQ);

  state_t          state, state_nx;
  logic [2:0]      win, win_nx, ptr, ptr_nx;
  logic            win_op, win_op_nx, cap, cap_nx;
  logic [3:0]      gap_cnt, gap_nx, win_cnt, win_cnt_nx;
  logic [NREQ-1:0] gnt_nx, gnt_sel;
  logic            done_nx, rd_data_nx, busy_nx, stored_nx, spur_nx, set_nx, reset_nx;
  logic [2:0]      done_id_nx;

  logic [2*NREQ-1:0] req2;
  logic              found, op_sel, gap_ok;
  logic [2:0]        off, pick;
  logic [3:0]        sum;

  // Rotate requests so bit 0 is the round-robin start, then map back.
  always_comb begin
    req2    = {req, req} >> ptr;
    found   = 1'b0;
    off     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req2[i]) begin
        found = 1'b1;
        off   = i[2:0];
      end
    end
    sum     = {1'b0, ptr} + {1'b0, off};
    sum     = (sum >= NR4) ? (sum - NR4) : sum;
    pick    = sum[2:0];
    op_sel  = 1'b0;
    gnt_sel = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (pick == j[2:0]) begin
        op_sel     = op[j];
        gnt_sel[j] = 1'b1;
      end
    end
  end

  assign gap_ok = (gap_cnt <= 4'd1);

  always_comb begin
    state_nx   = state;
    win_nx     = win;
    win_op_nx  = win_op;
    ptr_nx     = ptr;
    cap_nx     = cap;
    win_cnt_nx = win_cnt;
    gap_nx     = (gap_cnt != 4'd0) ? gap_cnt - 4'd1 : 4'd0;
    gnt_nx     = '0;
    done_nx    = 1'b0;
    done_id_nx = done_id;
    rd_data_nx = 1'b0;
    set_nx     = 1'b0;
    reset_nx   = 1'b0;
    stored_nx  = stored;
    spur_nx    = spur | (dro_out & (state != RDWIN));

    case (state)
      IDLE: begin
        if (found) begin
          state_nx  = GNT;
          win_nx    = pick;
          win_op_nx = op_sel;
          ptr_nx    = (pick == LAST) ? 3'd0 : pick + 3'd1;
          gnt_nx    = gnt_sel;
        end
      end
      GNT, WAIT: begin
        if (gap_ok) begin
          state_nx = PULSE;
          if (win_op) begin
            set_nx     = 1'b1;
            done_nx    = 1'b1;
            done_id_nx = win;
            gap_nx     = 4'(SET_GAP);
          end else begin
            reset_nx   = 1'b1;
            gap_nx     = 4'(RST_GAP);
          end
        end else begin
          state_nx = WAIT;
        end
      end
      PULSE: begin
        if (win_op) begin
          stored_nx = 1'b1;
          state_nx  = IDLE;
        end else begin
          stored_nx  = 1'b0;
          cap_nx     = 1'b0;
          win_cnt_nx = 4'(RD_WIN - 1);
          state_nx   = RDWIN;
          if (RD_WIN == 1) begin
            done_nx    = 1'b1;
            done_id_nx = win;
            rd_data_nx = dro_out;
          end
        end
      end
      RDWIN: begin
        cap_nx = cap | dro_out;
        // done is registered, so it is raised from the second-to-last window
        // cycle; the final cycle's sample only serves the spur guard.
        if (win_cnt == 4'd1) begin
          done_nx    = 1'b1;
          done_id_nx = win;
          rd_data_nx = cap | dro_out;
        end
        if (win_cnt == 4'd0) state_nx = IDLE;
        else                 win_cnt_nx = win_cnt - 4'd1;
      end
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      win       <= '0;
      win_op    <= 1'b0;
      ptr       <= '0;
      cap       <= 1'b0;
      gap_cnt   <= '0;
      win_cnt   <= '0;
      gnt       <= '0;
      done      <= 1'b0;
      done_id   <= '0;
      rd_data   <= 1'b0;
      busy      <= 1'b0;
      stored    <= 1'b0;
      spur      <= 1'b0;
      dro_set   <= 1'b0;
      dro_reset <= 1'b0;
    end else begin
      state     <= state_nx;
      win       <= win_nx;
      win_op    <= win_op_nx;
      ptr       <= ptr_nx;
      cap       <= cap_nx;
      gap_cnt   <= gap_nx;
      win_cnt   <= win_cnt_nx;
      gnt       <= gnt_nx;
      done      <= done_nx;
      done_id   <= done_id_nx;
      rd_data   <= rd_data_nx;
      busy      <= busy_nx;
      stored    <= stored_nx;
      spur      <= spur_nx;
      dro_set   <= set_nx;
      dro_reset <= reset_nx;
    end
  end

endmodule
